// File: rtl/viterbi_acs_sched.sv
// Viterbi ACS scheduler: sequences one received symbol pair through the
// shared BMC/ACS bank group by group, commits the survivor column, manages
// path-metric ping-pong and normalisation, and launches traceback at the end
// of a window or on flush.
//
// Symbol handshake: a pair is transferred on a rising edge where both
// sym_valid and sym_ready are 1; rx_pair_in is sampled only on that edge.
// sym_ready depends on registered state only, never on sym_valid.
module viterbi_acs_sched #(
   parameter  int GROUPS = 4,
   parameter  int TB_LEN = 32,
   localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1,
   localparam int SW     = $clog2(TB_LEN)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          sym_valid,
   output logic          sym_ready,
   input  logic [1:0]    rx_pair_in,
   input  logic          flush,
   output logic [1:0]    bmc_rx_pair,
   output logic          acs_en,
   output logic [GW-1:0] acs_grp,
   input  logic          acs_msb_any,
   output logic          acs_norm,
   output logic          pm_rd_sel,
   output logic          sp_we,
   output logic [SW-1:0] sp_addr,
   output logic          tb_start,
   output logic [SW-1:0] tb_last,
   input  logic          tb_done,
   output logic          busy,
   output logic [1:0]    dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_COMMIT = 2'd2,
      S_TB     = 2'd3
   } state_t;

   state_t        r_state;
   logic [GW-1:0] r_grp;
   logic [SW-1:0] r_step;
   logic [SW-1:0] r_tb_last;
   logic [1:0]    r_bmc_rx_pair;
   logic          r_pm_rd_sel;
   logic          r_norm_pend;
   logic          r_flush_pend;
   logic          r_msb_seen;
   logic          r_tb_start;

   // Scheduler FSM: all sequencing state, ping-pong, normalisation and flush bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_grp         <= '0;
         r_step        <= '0;
         r_tb_last     <= '0;
         r_bmc_rx_pair <= '0;
         r_pm_rd_sel   <= 1'b0;
         r_norm_pend   <= 1'b0;
         r_flush_pend  <= 1'b0;
         r_msb_seen    <= 1'b0;
         r_tb_start    <= 1'b0;
      end else begin
         // tb_start is a one-cycle pulse on TB entry; default low.
         r_tb_start <= 1'b0;
         // A flush request is remembered from any state until it is served.
         if (flush) begin
            r_flush_pend <= 1'b1;
         end
         case (r_state)
            S_IDLE: begin
               if (r_flush_pend) begin
                  if (r_step == '0) begin
                     // Nothing committed in this window: drop the request.
                     r_flush_pend <= flush;
                  end else begin
                     r_state    <= S_TB;
                     r_tb_start <= 1'b1;
                     r_tb_last  <= r_step - SW'(1);
                     r_step     <= '0;
                  end
               end else if (sym_valid) begin
                  r_bmc_rx_pair <= rx_pair_in;
                  r_grp         <= '0;
                  r_msb_seen    <= 1'b0;
                  r_state       <= S_RUN;
               end
            end
            S_RUN: begin
               r_msb_seen <= r_msb_seen | acs_msb_any;
               r_grp      <= r_grp + GW'(1);
               if (r_grp == GW'(GROUPS - 1)) begin
                  r_state <= S_COMMIT;
               end
            end
            S_COMMIT: begin
               r_pm_rd_sel <= ~r_pm_rd_sel;
               r_norm_pend <= r_msb_seen;
               if ((r_step == SW'(TB_LEN - 1)) || r_flush_pend) begin
                  r_state    <= S_TB;
                  r_tb_start <= 1'b1;
                  r_tb_last  <= r_step;
                  r_step     <= '0;
               end else begin
                  r_step  <= r_step + SW'(1);
                  r_state <= S_IDLE;
               end
            end
            S_TB: begin
               if (tb_done) begin
                  r_flush_pend <= flush;
                  r_state      <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Output decode from registered state only.
   assign sym_ready   = (r_state == S_IDLE) && !r_flush_pend;
   assign acs_en      = (r_state == S_RUN);
   assign acs_grp     = r_grp;
   assign acs_norm    = (r_state == S_RUN) && r_norm_pend;
   assign sp_we       = (r_state == S_COMMIT);
   assign sp_addr     = r_step;
   assign tb_start    = r_tb_start;
   assign tb_last     = r_tb_last;
   assign pm_rd_sel   = r_pm_rd_sel;
   assign bmc_rx_pair = r_bmc_rx_pair;
   assign busy        = (r_state != S_IDLE);
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_viterbi_acs_sched.sv
// Bench for viterbi_acs_sched: directed symbol sequences, a scoreboard of
// expected strobe events (ACS group, survivor write, traceback start) and
// direct checks of reset values and cycle-exact latency.
module tb_viterbi_acs_sched;
   localparam int GROUPS = 4;
   localparam int TB_LEN = 32;
   localparam int W      = 10;

   logic       clk = 1'b0;
   logic       rst;
   logic       sym_valid;
   logic       sym_ready;
   logic [1:0] rx_pair_in;
   logic       flush;
   logic [1:0] bmc_rx_pair;
   logic       acs_en;
   logic [1:0] acs_grp;
   logic       acs_msb_any;
   logic       acs_norm;
   logic       pm_rd_sel;
   logic       sp_we;
   logic [4:0] sp_addr;
   logic       tb_start;
   logic [4:0] tb_last;
   logic       tb_done;
   logic       tb_done_resp;
   logic       tb_done_stray;
   logic       busy;
   logic [1:0] dbg_state;

   int errors = 0;
   int checks = 0;
   int tb_cnt = 0;
   int sp_cnt = 0;

   logic [W-1:0] exp_q[$];

   // Bench model of the committed-column position.
   int   m_step = 0;
   logic m_pm   = 1'b0;
   logic m_norm = 1'b0;

   assign tb_done = tb_done_resp | tb_done_stray;

   viterbi_acs_sched #(.GROUPS(GROUPS), .TB_LEN(TB_LEN)) dut (
      .clk(clk), .rst(rst), .sym_valid(sym_valid), .sym_ready(sym_ready),
      .rx_pair_in(rx_pair_in), .flush(flush), .bmc_rx_pair(bmc_rx_pair),
      .acs_en(acs_en), .acs_grp(acs_grp), .acs_msb_any(acs_msb_any),
      .acs_norm(acs_norm), .pm_rd_sel(pm_rd_sel), .sp_we(sp_we),
      .sp_addr(sp_addr), .tb_start(tb_start), .tb_last(tb_last),
      .tb_done(tb_done), .busy(busy), .dbg_state(dbg_state)
   );

   // Clock and watchdog.
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Event word: {kind, pair, flag, field}; kind 1=ACS, 2=survivor write, 3=traceback start.
   function automatic logic [W-1:0] mk(input logic [1:0] k, input logic [1:0] a,
                                       input logic b, input logic [4:0] c);
      return {k, a, b, c};
   endfunction

   // Monitor: pops one expected event per strobe cycle.
   always @(negedge clk) begin
      int n;
      logic [W-1:0] obs;
      n = int'(acs_en) + int'(sp_we) + int'(tb_start);
      if (n != 0) begin
         chk("strobe_exclusive", 32'(n), 32'(1));
         if (acs_en)
            obs = mk(2'd1, bmc_rx_pair, acs_norm, {3'b000, acs_grp});
         else if (sp_we)
            obs = mk(2'd2, 2'b00, pm_rd_sel, sp_addr);
         else
            obs = mk(2'd3, 2'b00, 1'b0, tb_last);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got %0h with no event expected", obs);
         end else begin
            chk("event", 32'(obs), 32'(exp_q.pop_front()));
         end
         if (tb_start) tb_cnt++;
         if (sp_we) sp_cnt++;
      end
   end

   // Traceback unit stand-in: answers each tb_start after a few cycles.
   initial begin
      tb_done_resp = 1'b0;
      forever begin
         @(negedge clk);
         if (tb_start) begin
            repeat (3) begin
               @(negedge clk);
               chk("sym_ready_in_tb", 32'(sym_ready), 32'(0));
               chk("busy_in_tb", 32'(busy), 32'(1));
            end
            @(posedge clk); #1 tb_done_resp = 1'b1;
            @(posedge clk); #1 tb_done_resp = 1'b0;
         end
      end
   end

   task automatic wait_ready();
      int n = 0;
      while (!sym_ready && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 300) begin
         checks++;
         errors++;
         $display("FAIL wait_ready_timeout: sym_ready low for %0d cycles, required 1 within 300", n);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_sym_ready"}, 32'(sym_ready), 32'(1));
      chk({tag, "_busy"}, 32'(busy), 32'(0));
      chk({tag, "_acs_en"}, 32'(acs_en), 32'(0));
      chk({tag, "_sp_we"}, 32'(sp_we), 32'(0));
      chk({tag, "_tb_start"}, 32'(tb_start), 32'(0));
      chk({tag, "_pm_rd_sel"}, 32'(pm_rd_sel), 32'(0));
      chk({tag, "_sp_addr"}, 32'(sp_addr), 32'(0));
      chk({tag, "_bmc_rx_pair"}, 32'(bmc_rx_pair), 32'(0));
      chk({tag, "_acs_grp"}, 32'(acs_grp), 32'(0));
      chk({tag, "_state"}, 32'(dbg_state), 32'(0));
   endtask

   // Driver: offers one symbol, raises acs_msb_any in the grp1 cycle when msb=1,
   // optionally raises flush in the grp0 cycle; pushes the expected events.
   task automatic send_sym(input logic [1:0] p, input logic msb, input logic fl);
      wait_ready();
      for (int g = 0; g < GROUPS; g++)
         exp_q.push_back(mk(2'd1, p, m_norm, 5'(g)));
      exp_q.push_back(mk(2'd2, 2'b00, m_pm, 5'(m_step)));
      m_pm   = ~m_pm;
      m_norm = msb;
      if (m_step == TB_LEN - 1 || fl) begin
         exp_q.push_back(mk(2'd3, 2'b00, 1'b0, 5'(m_step)));
         m_step = 0;
      end else begin
         m_step++;
      end
      sym_valid = 1'b1; rx_pair_in = p;
      @(posedge clk); #1;
      sym_valid = 1'b0; rx_pair_in = ~p; flush = fl;
      @(posedge clk); #1;
      flush = 1'b0; acs_msb_any = msb;
      @(posedge clk); #1;
      acs_msb_any = 1'b0;
   endtask

   task automatic do_flush();
      wait_ready();
      if (m_step != 0)
         exp_q.push_back(mk(2'd3, 2'b00, 1'b0, 5'(m_step - 1)));
      m_step = 0;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
   endtask

   // Main stimulus.
   initial begin
      int sp0;
      int tb0;
      rst = 1'b1; sym_valid = 1'b0; rx_pair_in = 2'b00; flush = 1'b0;
      acs_msb_any = 1'b0; tb_done_stray = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check_reset_vals("por");

      // Single symbol 2'b10: cycle-exact latency.
      for (int g = 0; g < GROUPS; g++)
         exp_q.push_back(mk(2'd1, 2'b10, 1'b0, 5'(g)));
      exp_q.push_back(mk(2'd2, 2'b00, 1'b0, 5'd0));
      m_step = 1; m_pm = 1'b1; m_norm = 1'b0;
      sym_valid = 1'b1; rx_pair_in = 2'b10;
      @(posedge clk); #1;
      sym_valid = 1'b0; rx_pair_in = 2'b01;
      for (int k = 0; k < GROUPS; k++) begin
         chk("lat_acs_en", 32'(acs_en), 32'(1));
         chk("lat_acs_grp", 32'(acs_grp), 32'(k));
         chk("lat_sym_ready_run", 32'(sym_ready), 32'(0));
         @(posedge clk); #1;
      end
      chk("lat_sp_we", 32'(sp_we), 32'(1));
      chk("lat_sp_addr", 32'(sp_addr), 32'(0));
      @(posedge clk); #1;
      chk("lat_pm_rd_sel", 32'(pm_rd_sel), 32'(1));
      chk("lat_sym_ready", 32'(sym_ready), 32'(1));
      chk("lat_bmc_pair", 32'(bmc_rx_pair), 32'(2'b10));

      // Normalisation follows the symbol after the MSB was seen.
      send_sym(2'b11, 1'b1, 1'b0);
      send_sym(2'b00, 1'b0, 1'b0);
      send_sym(2'b01, 1'b0, 1'b0);
      send_sym(2'b10, 1'b0, 1'b0);

      // Flush after 5 committed symbols: tb_last=4, next column is 0.
      do_flush();
      send_sym(2'b11, 1'b0, 1'b0);

      // Flush raised during RUN: traceback right after that commit.
      send_sym(2'b01, 1'b0, 1'b1);

      // Full window of back-to-back symbols.
      wait_ready();
      sp0 = sp_cnt; tb0 = tb_cnt;
      for (int i = 0; i < TB_LEN; i++)
         send_sym(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), 1'b0);
      wait_ready();
      chk("window_sp_we_count", 32'(sp_cnt - sp0), 32'(TB_LEN));
      chk("window_tb_start_count", 32'(tb_cnt - tb0), 32'(1));
      send_sym(2'b00, 1'b1, 1'b0);

      // Make the ping-pong bank and norm_pend nonzero before a mid-RUN reset.
      if (m_pm == 1'b0) send_sym(2'b10, 1'b1, 1'b0);
      wait_ready();
      chk("pre_reset_pm", 32'(pm_rd_sel), 32'(1));

      // Reset at RUN grp=2: no commit for the abandoned step.
      for (int g = 0; g < 3; g++)
         exp_q.push_back(mk(2'd1, 2'b11, m_norm, 5'(g)));
      sym_valid = 1'b1; rx_pair_in = 2'b11;
      @(posedge clk); #1;
      sym_valid = 1'b0;
      @(posedge clk); #1;
      tb_done_stray = 1'b1;
      @(posedge clk); #1;
      tb_done_stray = 1'b0;
      chk("mid_run_grp", 32'(acs_grp), 32'(2));
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_reset_vals("mid_run_rst");
      m_step = 0; m_pm = 1'b0; m_norm = 1'b0;

      // Flush with no committed column, with sym_valid offered while not ready.
      tb0 = tb_cnt;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; sym_valid = 1'b1; rx_pair_in = 2'b10;
      chk("empty_flush_ready_low", 32'(sym_ready), 32'(0));
      @(posedge clk); #1;
      sym_valid = 1'b0;
      chk("empty_flush_ready", 32'(sym_ready), 32'(1));
      chk("empty_flush_busy", 32'(busy), 32'(0));
      chk("empty_flush_pair_not_sampled", 32'(bmc_rx_pair), 32'(0));
      repeat (5) @(posedge clk);
      #1;
      chk("empty_flush_no_tb", 32'(tb_cnt - tb0), 32'(0));

      // After reset: column 0, bank 0, no normalisation.
      send_sym(2'b01, 1'b0, 1'b0);
      wait_ready();
      repeat (4) @(posedge clk);
      #1;
      chk("queue_empty", 32'(exp_q.size()), 32'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
